inv_butterfly_pipe: RTL and testbench
=====================================

INV_BUTTERFLY_PIPE -- requirements
Module: inv_butterfly_pipe

Interface
REQ-001 Parameter WIDTH, default 8: signed two's-complement width of every data and twiddle port.
REQ-002 Parameter FRACTION_BITS, default 5: fractional bits of the twiddle format; 1.0 = 2^FRACTION_BITS.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_even_real, in_even_imag  input  WIDTH each  signed butterfly even output E.
REQ-008 in_odd_real, in_odd_imag  input  WIDTH each  signed butterfly odd output O.
REQ-009 twiddle_factor_real, twiddle_factor_imag  input  WIDTH each  signed twiddle W used by the forward butterfly.
REQ-010 out_valid  output  1  output beat present.
REQ-011 out_ready  input  1  downstream accepts the output beat.
REQ-012 out_1_real, out_1_imag  output  WIDTH each  recovered first operand A.
REQ-013 out_2_real, out_2_imag  output  WIDTH each  recovered second operand B.

Function
REQ-014 The block shall invert the radix-2 DIT butterfly: A = (E+O)/2 and B = conj(W)*(E-O)/2.
REQ-015 A beat shall be accepted on a cycle where in_valid and in_ready are both 1. The twiddle shall be sampled together with E and O.
REQ-016 Stage 1 shall compute E+O and E-O per component at WIDTH+1 bits, then arithmetic-shift right by 1 (floor) and truncate to WIDTH.
REQ-017 Stage 2 shall compute, at 2*WIDTH+1 bits, real = dr*wr + di*wi and imag = di*wr - dr*wi, where d is the halved difference. It shall then arithmetic-shift right by FRACTION_BITS and truncate to WIDTH (wrap, no saturation).
REQ-018 A shall travel alongside the stage-2 product so that A and B of the same beat emerge together.
REQ-019 Stage 3 shall register the outputs. Latency from acceptance to out_valid shall be exactly 3 cycles when no stall occurs.
REQ-020 Stall condition: out_valid=1 and out_ready=0.
- During a stall, every stage and the outputs shall hold their values.
- in_ready shall equal the negation of the stall condition, combinationally.
REQ-021 Bubbles shall collapse: a stage whose valid bit is 0 shall load even during a stall.
- in_ready may therefore be 1 while out_valid=1 and out_ready=0, provided a bubble exists upstream of the output.
- If this rule is adopted, REQ-020 shall use it in place of the plain stall rule. Chosen: in_ready = !(v1 & v2 & v3 & !out_ready).
REQ-022 Full-rate throughput shall be one beat per cycle with out_ready held at 1.
REQ-023 The output data shall remain stable while out_valid=1 and out_ready=0.
REQ-024 A beat accepted on the same cycle as an output is consumed shall not be lost or duplicated.

Reset
REQ-025 When RST=1 at a clock edge:
- all stage valid bits and out_valid shall clear to 0;
- all data registers shall clear to 0;
- in_ready shall be 1 in the following cycle.
REQ-026 Reset during operation shall discard every in-flight beat. No beat accepted before reset shall appear after it.
REQ-027 in_valid asserted in the same cycle as RST=1 shall be ignored.

Structure
REQ-028 A shared package shall hold the default WIDTH and FRACTION_BITS values and the stage count constant (3).
REQ-029 The conjugate complex multiply of REQ-017 shall be a sub-module named cmpx_conj_mul, parameterised by WIDTH and returning 2*WIDTH+1-bit results.
REQ-030 The valid/stall control shall live in the top module. No other sub-modules are required.

Verification (WIDTH=8, FRACTION_BITS=5)
REQ-031 Identity twiddle:
- Stimulus: E=(40,8), O=(8,-8), W=(32,0), out_ready=1.
- Required: A=(24,0), B=(16,8), out_valid exactly 3 cycles after acceptance.
REQ-032 Twiddle j:
- Stimulus: E=(40,8), O=(8,-8), W=(0,32).
- Required: A=(24,0), B=(8,-16).
REQ-033 Floor rounding:
- Stimulus: E=(-3,0), O=(0,0), W=(32,0).
- Required: A=(-2,0), B=(-2,0).
REQ-034 Backpressure:
- Stimulus: 5 back-to-back beats; out_ready=0 for 4 cycles once the first output appears.
- Required: in_ready drops to 0 once all 3 stages are full; outputs hold; all 5 results emerge in order with no loss or duplication.
REQ-035 Reset mid-stream:
- Stimulus: RST for 1 cycle while 3 beats are in flight.
- Required: out_valid=0 the next cycle; none of those 3 beats is ever output.
REQ-036 Wrap:
- Stimulus: E=(127,0), O=(-128,0), W=(32,0).
- Required: A=(-1,0), B=(127,0).

Source files
------------

// File: rtl/inv_butterfly_pipe_pkg.sv
// Shared constants for the inverse radix-2 butterfly pipeline.
package inv_butterfly_pipe_pkg;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_FRACTION_BITS = 5;
  localparam int unsigned NUM_STAGES        = 3;

endpackage

// File: rtl/inv_butterfly_pipe_cmpx_conj_mul.sv
// Combinational conj(W)*D with full-precision 2*WIDTH+1-bit results.
module cmpx_conj_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] dr,
  input  logic [WIDTH-1:0] di,
  input  logic [WIDTH-1:0] wr,
  input  logic [WIDTH-1:0] wi,
  output logic [2*WIDTH:0] re,
  output logic [2*WIDTH:0] im
);

  logic signed [2*WIDTH:0] drx, dix, wrx, wix;

  always_comb begin
    drx = $signed({{(WIDTH+1){dr[WIDTH-1]}}, dr});
    dix = $signed({{(WIDTH+1){di[WIDTH-1]}}, di});
    wrx = $signed({{(WIDTH+1){wr[WIDTH-1]}}, wr});
    wix = $signed({{(WIDTH+1){wi[WIDTH-1]}}, wi});
    re  = drx * wrx + dix * wix;
    im  = dix * wrx - drx * wix;
  end

endmodule

// File: rtl/inv_butterfly_pipe.sv
// Three-stage inverse DIT butterfly: A = (E+O)/2, B = conj(W)*(E-O)/2.
module inv_butterfly_pipe
  import inv_butterfly_pipe_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned FRACTION_BITS = DEF_FRACTION_BITS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_even_real,
  input  logic [WIDTH-1:0] in_even_imag,
  input  logic [WIDTH-1:0] in_odd_real,
  input  logic [WIDTH-1:0] in_odd_imag,
  input  logic [WIDTH-1:0] twiddle_factor_real,
  input  logic [WIDTH-1:0] twiddle_factor_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_1_real,
  output logic [WIDTH-1:0] out_1_imag,
  output logic [WIDTH-1:0] out_2_real,
  output logic [WIDTH-1:0] out_2_imag
);

  logic [NUM_STAGES-1:0] vld;
  logic [NUM_STAGES-1:0] en;

  logic [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
  logic [WIDTH-1:0] s1_a_re, s1_a_im, s1_d_re, s1_d_im, s1_w_re, s1_w_im;
  logic [WIDTH-1:0] s2_a_re, s2_a_im, s2_b_re, s2_b_im;
  logic [2*WIDTH:0] prod_re, prod_im;

  // A stage may load whenever it is empty or the stage after it moves,
  // so bubbles collapse even while the output is stalled.
  always_comb begin
    en[2]    = !vld[2] | out_ready;
    en[1]    = !vld[1] | en[2];
    en[0]    = !vld[0] | en[1];
    in_ready = en[0];
  end

  always_comb begin
    sum_re = {in_even_real[WIDTH-1], in_even_real} + {in_odd_real[WIDTH-1], in_odd_real};
    sum_im = {in_even_imag[WIDTH-1], in_even_imag} + {in_odd_imag[WIDTH-1], in_odd_imag};
    dif_re = {in_even_real[WIDTH-1], in_even_real} - {in_odd_real[WIDTH-1], in_odd_real};
    dif_im = {in_even_imag[WIDTH-1], in_even_imag} - {in_odd_imag[WIDTH-1], in_odd_imag};
  end

  cmpx_conj_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .dr(s1_d_re),
    .di(s1_d_im),
    .wr(s1_w_re),
    .wi(s1_w_im),
    .re(prod_re),
    .im(prod_im)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld        <= '0;
      s1_a_re    <= '0;
      s1_a_im    <= '0;
      s1_d_re    <= '0;
      s1_d_im    <= '0;
      s1_w_re    <= '0;
      s1_w_im    <= '0;
      s2_a_re    <= '0;
      s2_a_im    <= '0;
      s2_b_re    <= '0;
      s2_b_im    <= '0;
      out_1_real <= '0;
      out_1_imag <= '0;
      out_2_real <= '0;
      out_2_imag <= '0;
    end else begin
      if (en[0]) begin
        vld[0]  <= in_valid;
        // Dropping bit 0 of the (WIDTH+1)-bit sum is a floor divide by two.
        s1_a_re <= WIDTH'(sum_re >> 1);
        s1_a_im <= WIDTH'(sum_im >> 1);
        s1_d_re <= WIDTH'(dif_re >> 1);
        s1_d_im <= WIDTH'(dif_im >> 1);
        s1_w_re <= twiddle_factor_real;
        s1_w_im <= twiddle_factor_imag;
      end
      if (en[1]) begin
        vld[1]  <= vld[0];
        s2_a_re <= s1_a_re;
        s2_a_im <= s1_a_im;
        s2_b_re <= WIDTH'(prod_re >> FRACTION_BITS);
        s2_b_im <= WIDTH'(prod_im >> FRACTION_BITS);
      end
      if (en[2]) begin
        vld[2]     <= vld[1];
        out_1_real <= s2_a_re;
        out_1_imag <= s2_a_im;
        out_2_real <= s2_b_re;
        out_2_imag <= s2_b_im;
      end
    end
  end

  assign out_valid = vld[2];

endmodule

// File: tb/tb_inv_butterfly_pipe.sv
// Self-checking bench for inv_butterfly_pipe: vector table plus scoreboard.
module tb_inv_butterfly_pipe;

  localparam int unsigned W = 8;
  localparam int unsigned F = 5;

  typedef struct {
    int er, ei, orr, oi, wr, wi;
    int ar, ai, br, bi;
  } vec_t;

  typedef struct {
    int ar, ai, br, bi;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_even_real, in_even_imag, in_odd_real, in_odd_imag;
  logic [W-1:0] twiddle_factor_real, twiddle_factor_imag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_1_real, out_1_imag, out_2_real, out_2_imag;

  int   checks = 0;
  int   errors = 0;
  int   rx = 0;
  bit   last_acc;
  bit   last_blocked;
  exp_t pend;
  exp_t q[$];
  vec_t tbl[7];

  inv_butterfly_pipe #(
    .WIDTH(W),
    .FRACTION_BITS(F)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_even_real(in_even_real),
    .in_even_imag(in_even_imag),
    .in_odd_real(in_odd_real),
    .in_odd_imag(in_odd_imag),
    .twiddle_factor_real(twiddle_factor_real),
    .twiddle_factor_imag(twiddle_factor_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_1_real(out_1_real),
    .out_1_imag(out_1_imag),
    .out_2_real(out_2_real),
    .out_2_imag(out_2_imag)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int wrap8(input int x);
    return ((x + 128) & 255) - 128;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t e;
    int dr, di;
    e.ar = wrap8((v.er + v.orr) >>> 1);
    e.ai = wrap8((v.ei + v.oi) >>> 1);
    dr   = wrap8((v.er - v.orr) >>> 1);
    di   = wrap8((v.ei - v.oi) >>> 1);
    e.br = wrap8((dr * v.wr + di * v.wi) >>> F);
    e.bi = wrap8((di * v.wr - dr * v.wi) >>> F);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid            = 1'b1;
    in_even_real        = W'(v.er);
    in_even_imag        = W'(v.ei);
    in_odd_real         = W'(v.orr);
    in_odd_imag         = W'(v.oi);
    twiddle_factor_real = W'(v.wr);
    twiddle_factor_imag = W'(v.wi);
    pend                = '{v.ar, v.ai, v.br, v.bi};
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    exp_t e;
    v.er  = int'($urandom_range(255)) - 128;
    v.ei  = int'($urandom_range(255)) - 128;
    v.orr = int'($urandom_range(255)) - 128;
    v.oi  = int'($urandom_range(255)) - 128;
    v.wr  = int'($urandom_range(255)) - 128;
    v.wi  = int'($urandom_range(255)) - 128;
    e = model(v);
    v.ar = e.ar; v.ai = e.ai; v.br = e.br; v.bi = e.bi;
    return v;
  endfunction

  // Evaluate the handshakes that the coming rising edge will act on, then
  // advance to the next falling edge where the caller drives new inputs.
  task automatic cycle();
    #1;
    last_acc     = 1'b0;
    last_blocked = in_valid && !in_ready;
    if (RST) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          chk("A.re", $signed(out_1_real), q[0].ar);
          chk("A.im", $signed(out_1_imag), q[0].ai);
          chk("B.re", $signed(out_2_real), q[0].br);
          chk("B.im", $signed(out_2_imag), q[0].bi);
          if (out_ready) begin
            void'(q.pop_front());
            rx++;
          end
        end
      end
      if (out_ready) chk("in_ready_when_out_ready", int'(in_ready), 1);
      if (in_valid && in_ready) begin
        q.push_back(pend);
        last_acc = 1'b1;
      end
    end
    @(negedge CLK);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      cycle();
      n++;
    end
    chk("drain_done", int'(q.size() == 0 && !out_valid), 1);
  endtask

  initial begin
    vec_t v;
    int   found, sent, stall, pre;
    bit   started, saw_block;

    tbl[0] = '{40, 8, 8, -8, 32, 0, 24, 0, 16, 8};
    tbl[1] = '{40, 8, 8, -8, 0, 32, 24, 0, 8, -16};
    tbl[2] = '{-3, 0, 0, 0, 32, 0, -2, 0, -2, 0};
    tbl[3] = '{127, 0, -128, 0, 32, 0, -1, 0, 127, 0};
    tbl[4] = '{40, 8, 8, -8, -32, 0, 24, 0, -16, -8};
    tbl[5] = '{40, 8, 8, -8, 23, -23, 24, 0, 5, 17};
    tbl[6] = '{-128, -128, -128, -128, 32, 32, -128, -128, 0, 0};

    // Reset with in_valid high: the beat must be ignored.
    RST = 1'b1;
    out_ready = 1'b1;
    drive(tbl[0]);
    @(negedge CLK);
    cycle();
    cycle();
    RST = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_1_real", int'(out_1_real), 0);
    chk("rst_out_2_imag", int'(out_2_imag), 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("idle_after_rst", int'(out_valid), 0);
    end

    // Acceptance-to-output latency.
    drive(tbl[0]);
    cycle();
    chk("lat_accept", int'(last_acc), 1);
    in_valid = 1'b0;
    found = 0;
    for (int n = 1; n <= 8; n++) begin
      if (found == 0 && out_valid) found = n;
      cycle();
    end
    chk("latency", found, 3);
    drain();

    // Vector table at full rate.
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i]);
      cycle();
      chk("table_accept", int'(last_acc), 1);
    end
    drain();

    // Bubble collapse: single beat stalled at the output leaves in_ready high.
    out_ready = 1'b0;
    drive(tbl[5]);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("bubble_out_valid", int'(out_valid), 1);
    chk("bubble_in_ready", int'(in_ready), 1);
    drain();

    // Backpressure: 5 back-to-back beats, 4-cycle stall at first output.
    sent = 0; stall = 0; started = 0; saw_block = 0; pre = rx;
    out_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (sent < 5) begin
        v = rand_vec();
        v.er = 10 * sent; v.ei = -sent;
        v.ar = model(v).ar; v.ai = model(v).ai; v.br = model(v).br; v.bi = model(v).bi;
        drive(v);
      end else begin
        in_valid = 1'b0;
      end
      if (!started && out_valid) begin
        started = 1;
        stall = 4;
      end
      out_ready = (stall == 0);
      cycle();
      if (last_blocked && stall > 0) saw_block = 1;
      if (last_acc) sent++;
      if (stall > 0) stall--;
      if (sent == 5 && q.size() == 0 && !out_valid && started) break;
    end
    chk("bp_in_ready_dropped", int'(saw_block), 1);
    chk("bp_count", rx - pre, 5);
    drain();

    // Random traffic with random backpressure.
    sent = 0;
    for (int n = 0; n < 200 && sent < 40; n++) begin
      if ($urandom_range(3) != 0) drive(rand_vec());
      else in_valid = 1'b0;
      out_ready = ($urandom_range(9) < 7);
      cycle();
      if (last_acc) sent++;
    end
    chk("rand_sent", sent, 40);
    drain();

    // Reset mid-stream with three beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i]);
      cycle();
    end
    drive(tbl[3]);
    out_ready = 1'b0;
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("midrst_no_output", int'(out_valid), 0);
    end

    // Post-reset operation still works.
    drive(tbl[1]);
    cycle();
    drain();
    chk("final_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
